// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the mult/div sequencer.
package muldiv_ctrl_pkg;

    localparam int MD_WORD = 32;
    localparam int W_DATA  = MD_WORD;
    localparam int W_FUNC  = 4;

    localparam logic [W_FUNC-1:0] FUNC_MUL = 4'h1;
    localparam logic [W_FUNC-1:0] FUNC_DIV = 4'h2;

    localparam logic [MD_WORD-1:0] MD_DIV0_Q = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    function automatic logic [MD_WORD-1:0] md_mag(input logic neg, input logic [MD_WORD-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Combinational BITS_PER_CYC steps of shift-add multiply or restoring divide
// on a 64-bit {upper, lower} accumulator.
module muldiv_iter
    import muldiv_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYC = 1
) (
    input  logic                   is_div,
    input  logic [MD_WORD-1:0]     opd,
    input  logic [2*MD_WORD-1:0]   acc_i,
    output logic [2*MD_WORD-1:0]   acc_o
);

    logic [2*MD_WORD-1:0] acc;
    logic [MD_WORD:0]     sum;
    logic [MD_WORD+1:0]   diff;

    always_comb begin
        acc  = acc_i;
        sum  = '0;
        diff = '0;
        for (int k = 0; k < BITS_PER_CYC; k++) begin
            if (is_div) begin
                // Trial subtract of the divisor from the remainder shifted by one bit.
                diff = {1'b0, acc[2*MD_WORD-1:MD_WORD-1]} - {2'b00, opd};
                if (!diff[MD_WORD+1])
                    acc = {diff[MD_WORD-1:0], acc[MD_WORD-2:0], 1'b1};
                else
                    acc = {acc[2*MD_WORD-2:0], 1'b0};
            end else begin
                sum = {1'b0, acc[2*MD_WORD-1:MD_WORD]} + (acc[0] ? {1'b0, opd} : '0);
                acc = {sum, acc[MD_WORD-1:1]};
            end
        end
        acc_o = acc;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// mult/multu/div/divu sequencer and HI/LO owner.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle via `*`.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              sign_i,
    input  logic [W_FUNC-1:0] func_i,
    input  logic [W_DATA-1:0] opa_i,
    input  logic [W_DATA-1:0] opb_i,
    input  logic              flush_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    input  logic [W_DATA-1:0] mtdata_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic [W_DATA-1:0] hi_o,
    output logic [W_DATA-1:0] lo_o
);

    localparam int N     = MD_WORD / BITS_PER_CYC;
    localparam int CNT_W = $clog2(N);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    md_state_t            state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div, res_neg, rem_neg, div0;
    logic [MD_WORD-1:0]   opd, opa_raw, a_mag, b_mag;
    logic [2*MD_WORD-1:0] acc, acc_nx, prod;
    logic [MD_WORD-1:0]   hi_res, lo_res;
    logic                 func_ok, go, start_div;

    assign func_ok   = (func_i == FUNC_MUL) || (func_i == FUNC_DIV);
    assign go        = start_i & func_ok & ~flush_i;
    assign start_div = (func_i == FUNC_DIV);
    assign stall_o   = go & (state != MD_DONE);
    assign a_mag     = md_mag(sign_i & opa_i[MD_WORD-1], opa_i);
    assign b_mag     = md_mag(sign_i & opb_i[MD_WORD-1], opb_i);

    muldiv_iter #(.BITS_PER_CYC(BITS_PER_CYC)) u_iter (
        .is_div (is_div),
        .opd    (opd),
        .acc_i  (acc),
        .acc_o  (acc_nx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (go) state_nx = (FAST_MUL && !start_div) ? MD_DONE : MD_BUSY;
            MD_BUSY: begin
                if (flush_i)                       state_nx = MD_IDLE;
                else if (cnt == CNT_W'(N - 1))     state_nx = MD_DONE;
            end
            default: state_nx = MD_IDLE;
        endcase
    end

    // Sign fix-up of the raw magnitude result; divide-by-zero bypasses it.
    always_comb begin
        prod   = res_neg ? (64'd0 - acc) : acc;
        hi_res = prod[2*MD_WORD-1:MD_WORD];
        lo_res = prod[MD_WORD-1:0];
        if (is_div) begin
            if (div0) begin
                hi_res = opa_raw;
                lo_res = MD_DIV0_Q;
            end else begin
                hi_res = md_mag(rem_neg, acc[2*MD_WORD-1:MD_WORD]);
                lo_res = md_mag(res_neg, acc[MD_WORD-1:0]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MD_IDLE;
            busy_o  <= 1'b0;
            cnt     <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            div0    <= 1'b0;
            opd     <= '0;
            opa_raw <= '0;
            acc     <= '0;
        end else begin
            state  <= state_nx;
            busy_o <= (state_nx != MD_IDLE);
            cnt    <= (state == MD_BUSY && state_nx == MD_BUSY) ? cnt + 1'b1 : '0;
            if (state == MD_IDLE && go) begin
                is_div  <= start_div;
                res_neg <= sign_i & (opa_i[MD_WORD-1] ^ opb_i[MD_WORD-1]);
                rem_neg <= sign_i & opa_i[MD_WORD-1];
                div0    <= start_div && (opb_i == '0);
                opa_raw <= opa_i;
                opd     <= start_div ? b_mag : a_mag;
                if (FAST_MUL && !start_div)
                    acc <= {32'd0, a_mag} * {32'd0, b_mag};
                else
                    acc <= {32'd0, start_div ? a_mag : b_mag};
            end else if (state == MD_BUSY) begin
                acc <= acc_nx;
            end
            if (state == MD_DONE && !flush_i) begin
                hi_o <= hi_res;
                lo_o <= lo_res;
            end
            if (state == MD_IDLE && !start_i) begin
                if (mthi_i) hi_o <= mtdata_i;
                if (mtlo_i) lo_o <= mtdata_i;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; expected values hand-computed.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int BPC = 1;
    localparam int N   = 32 / BPC;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = N + 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, sign = 1'b0, flush = 1'b0;
    logic              mthi = 1'b0, mtlo = 1'b0;
    logic [W_FUNC-1:0] func = '0;
    logic [W_DATA-1:0] opa = '0, opb = '0, mtdata = '0;
    logic              stall_o, busy_o;
    logic [W_DATA-1:0] hi_o, lo_o;

    int total = 0;
    int bad   = 0;
    int ncyc;

    muldiv_ctrl #(.BITS_PER_CYC(BPC)) dut (
        .clk(clk), .rst(rst), .start_i(start), .sign_i(sign), .func_i(func),
        .opa_i(opa), .opb_i(opb), .flush_i(flush), .mthi_i(mthi), .mtlo_i(mtlo),
        .mtdata_i(mtdata), .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ((mthi || mtlo) && (busy_o || start))
            $error("mt write issued while sequencer not idle");

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W_FUNC-1:0] f, input logic s,
                          input logic [31:0] a, input logic [31:0] b, output int n);
        @(negedge clk);
        func = f; sign = s; opa = a; opb = b; start = 1'b1;
        #1;
        n = 0;
        while (stall_o && n < 200) begin
            n++;
            @(negedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        #1;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(FUNC_MUL, 1'b0, 32'hFFFFFFFF, 32'h2, ncyc);
        check("multu_hi", hi_o, 32'h00000001);
        check("multu_lo", lo_o, 32'hFFFFFFFE);
        check("multu_stall", ncyc, MUL_STALL);

        run_op(FUNC_MUL, 1'b1, 32'hFFFFFFFD, 32'd5, ncyc);
        check("mult_hi", hi_o, 32'hFFFFFFFF);
        check("mult_lo", lo_o, 32'hFFFFFFF1);
        run_op(FUNC_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, ncyc);
        check("div_lo", lo_o, 32'hFFFFFFFD);
        check("div_hi", hi_o, 32'hFFFFFFFF);
        check("div_stall", ncyc, N + 1);
        run_op(FUNC_DIV, 1'b0, 32'd7, 32'd2, ncyc);
        check("divu_lo", lo_o, 32'd3);
        check("divu_hi", hi_o, 32'd1);

        run_op(FUNC_DIV, 1'b0, 32'd5, 32'd0, ncyc);
        check("div0_lo", lo_o, 32'hFFFFFFFF);
        check("div0_hi", hi_o, 32'd5);
        check("div0_stall", ncyc, N + 1);
        run_op(FUNC_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, ncyc);
        check("ovf_lo", lo_o, 32'h80000000);
        check("ovf_hi", hi_o, 32'h0);

        // invalid func: no stall, no busy
        @(negedge clk);
        func = 4'h7; start = 1'b1; #1;
        check("badf_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk); #1;
        check("badf_busy", {31'd0, busy_o}, 32'd0);
        start = 1'b0;

        // preload both registers together, then flush a divide mid-flight
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; mtdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0; mtdata = 32'h5678; #1;
        check("mt_both_lo", lo_o, 32'h1234);
        @(negedge clk);
        mtlo = 1'b0; #1;
        check("mthi_hi", hi_o, 32'h1234);
        check("mtlo_lo", lo_o, 32'h5678);
        func = FUNC_DIV; sign = 1'b0; opa = 32'd100; opb = 32'd3; start = 1'b1;
        repeat (11) @(negedge clk);
        flush = 1'b1; #1;
        check("flush_stall", {31'd0, stall_o}, 32'd0);
        check("flush_busy_pre", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        flush = 1'b0; start = 1'b0; #1;
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        repeat (N + 4) @(negedge clk);
        #1;
        check("flush_hi", hi_o, 32'h1234);
        check("flush_lo", lo_o, 32'h5678);

        // async reset mid-BUSY
        @(negedge clk);
        func = FUNC_DIV; sign = 1'b0; opa = 32'd50; opb = 32'd7; start = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; start = 1'b0; #1;
        check("arst_hi", hi_o, 32'h0);
        check("arst_lo", lo_o, 32'h0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk); rst = 1'b0;
        run_op(FUNC_DIV, 1'b0, 32'd9, 32'd4, ncyc);
        check("post_rst_lo", lo_o, 32'd2);
        check("post_rst_hi", hi_o, 32'd1);

        run_op(FUNC_MUL, 1'b1, 32'd6, 32'd7, ncyc);
        check("mul67_lo", lo_o, 32'd42);
        check("mul67_hi", hi_o, 32'd0);
        check("mul67_stall", ncyc, MUL_STALL);
        run_op(FUNC_DIV, 1'b0, 32'd45, 32'd7, ncyc);
        check("divu45_lo", lo_o, 32'd6);
        check("divu45_hi", hi_o, 32'd3);
        check("divu45_stall", ncyc, N + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
